// File: rtl/pwm_capture.sv
// pwm_capture: measures high time, period and 8-bit duty of an asynchronous PWM input.
// A restoring shift-subtract divider turns (high, period) into duty = floor(high*256/period).
// An edge-free interval of TIMEOUT cycles flags the input as stuck.
module pwm_capture #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [7:0]       duty,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             stuck,
    output logic             overrun
);

    localparam int unsigned NUM_W = CNT_W + 8;
    localparam int unsigned DCW   = $clog2(NUM_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [DCW-1:0]   LAST    = DCW'(NUM_W);

    typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;

    state_t state, state_nxt;

    logic s1, s2, s3;
    logic rise, fall, edge_any;
    logic snap, timeout;

    logic [CNT_W-1:0] hc, pc, ec;

    logic             busy;
    logic [DCW-1:0]   dcnt;
    logic [NUM_W-1:0] quo;
    logic [CNT_W:0]   rem;
    logic [CNT_W-1:0] den;
    logic [CNT_W-1:0] dhc;
    logic             finishing, accept;

    logic [CNT_W:0]   rem_sh, rem_nx;
    logic             q_bit;

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign edge_any = rise | fall;
    assign timeout  = (ec == TO_VAL) && !stuck;

    // Busy clears on the finishing cycle, so a snapshot arriving then is taken.
    assign finishing = busy && (dcnt == LAST);
    assign accept    = snap && (!busy || finishing);

    // Two-flop synchronizer plus edge-detect register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a rise in MEAS_LOW closes a full period and snapshots it.
    always_comb begin
        state_nxt = state;
        snap      = 1'b0;
        case (state)
            IDLE:      if (rise) state_nxt = MEAS_HIGH;
            MEAS_HIGH: if (fall) state_nxt = MEAS_LOW;
            MEAS_LOW: begin
                if (rise) begin
                    snap      = 1'b1;
                    state_nxt = MEAS_HIGH;
                end
            end
            default:   state_nxt = IDLE;
        endcase
        if (timeout) begin
            state_nxt = IDLE;
            snap      = 1'b0;
        end
    end

    // High-time and period counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            hc <= '0;
            pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        hc <= CNT_W'(1);
                        pc <= CNT_W'(1);
                    end
                end
                MEAS_HIGH: begin
                    if (pc != CNT_MAX) pc <= pc + 1'b1;
                    if (!fall && hc != CNT_MAX) hc <= hc + 1'b1;
                end
                MEAS_LOW: begin
                    if (rise) begin
                        hc <= CNT_W'(1);
                        pc <= CNT_W'(1);
                    end else if (pc != CNT_MAX) begin
                        pc <= pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Edge-free cycle counter; holds once it reaches TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst)                ec <= '0;
        else if (edge_any)      ec <= '0;
        else if (ec != TO_VAL)  ec <= ec + 1'b1;
    end

    // One restoring division step.
    always_comb begin
        rem_sh = {rem[CNT_W-1:0], quo[NUM_W-1]};
        q_bit  = (rem_sh >= {1'b0, den});
        rem_nx = q_bit ? (rem_sh - {1'b0, den}) : rem_sh;
    end

    // Divider sequencing: load on snapshot, NUM_W steps, then one finishing cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            dcnt <= '0;
            quo  <= '0;
            rem  <= '0;
            den  <= '0;
            dhc  <= '0;
        end else if (timeout) begin
            busy <= 1'b0;
        end else if (accept) begin
            busy <= 1'b1;
            dcnt <= '0;
            quo  <= {hc, 8'h00};
            rem  <= '0;
            den  <= pc;
            dhc  <= hc;
        end else if (finishing) begin
            busy <= 1'b0;
        end else if (busy) begin
            rem  <= rem_nx;
            quo  <= {quo[NUM_W-2:0], q_bit};
            dcnt <= dcnt + 1'b1;
        end
    end

    // Output registers; a timeout overrides a divider result in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty      <= '0;
            high_time <= '0;
            period    <= '0;
            valid     <= 1'b0;
            stuck     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            valid   <= 1'b0;
            overrun <= snap && busy && !finishing;
            if (timeout) begin
                stuck     <= 1'b1;
                duty      <= s2 ? 8'hFF : 8'h00;
                high_time <= '0;
                period    <= '0;
                valid     <= 1'b1;
            end else begin
                if (finishing) begin
                    valid     <= 1'b1;
                    duty      <= (|quo[NUM_W-1:8]) ? 8'hFF : quo[7:0];
                    high_time <= dhc;
                    period    <= den;
                end
                if (edge_any) stuck <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed checks of pwm_capture against hand-computed results.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_in;
    logic [7:0]  duty;
    logic [15:0] high_time;
    logic [15:0] period;
    logic        valid;
    logic        stuck;
    logic        overrun;

    pwm_capture #(.CNT_W(16), .TIMEOUT(1023)) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .duty      (duty),
        .high_time (high_time),
        .period    (period),
        .valid     (valid),
        .stuck     (stuck),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int unsigned stamp;
        logic [7:0]  duty;
        logic [15:0] ht;
        logic [15:0] per;
        logic        stuck;
    } vrec_t;

    vrec_t       vq[$];
    int unsigned oq[$];
    int unsigned rq[$];

    // Cycle counter: value equals the index of the most recent posedge.
    always @(posedge clk) cyc++;

    // Record every valid and overrun pulse with its cycle stamp.
    always @(posedge clk) begin
        #1;
        if (valid === 1'b1) vq.push_back('{cyc, duty, high_time, period, stuck});
        if (overrun === 1'b1) oq.push_back(cyc);
    end

    // Reference PWM generator; logs the posedge at which each rise is first sampled.
    int unsigned gcnt = 0;
    int unsigned gen_period = 256;
    int unsigned gen_high = 128;
    logic gen_en = 1'b0;
    logic gen_out = 1'b0;
    logic pwm_man = 1'b0;

    always @(negedge clk) begin
        if (!gen_en) begin
            gcnt    = 0;
            gen_out = 1'b0;
        end else begin
            gen_out = (gcnt < gen_high);
            if (gcnt == 0) rq.push_back(cyc + 1);
            gcnt = (gcnt + 1 == gen_period) ? 0 : gcnt + 1;
        end
    end

    assign pwm_in = gen_en ? gen_out : pwm_man;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valids(input int unsigned n, input int unsigned budget,
                               input string tag, output bit ok);
        int unsigned k = 0;
        while (vq.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        ok = (vq.size() >= n);
        total++;
        assert (ok) else begin
            bad++;
            $error("FAIL %s: observed %0d valid pulses, expected %0d", tag, vq.size(), n);
        end
    endtask

    task automatic do_reset(output int unsigned r);
        rst = 1'b1;
        tick(2);
        r   = cyc;
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_duty"},    32'(duty),      32'd0);
        chk({tag, "_ht"},      32'(high_time), 32'd0);
        chk({tag, "_per"},     32'(period),    32'd0);
        chk({tag, "_valid"},   32'(valid),     32'd0);
        chk({tag, "_stuck"},   32'(stuck),     32'd0);
        chk({tag, "_overrun"}, 32'(overrun),   32'd0);
    endtask

    task automatic start_gen(input int unsigned p, input int unsigned h);
        gen_period = p;
        gen_high   = h;
        gen_en     = 1'b1;
    endtask

    initial begin
        int unsigned r, rb, vb, ob, n_ov, target, k;
        bit ok;

        tick(1);

        // Reset state.
        do_reset(r);
        check_zero("rst");

        // D=128: period 256, high 128; valid 25 cycles after snapshot (+2 sync).
        rb = rq.size();
        vb = vq.size();
        start_gen(256, 128);
        wait_valids(vb + 2, 900, "d128_wait", ok);
        if (ok) begin
            chk("d128_duty", 32'(vq[vb].duty), 32'd128);
            chk("d128_ht",   32'(vq[vb].ht),   32'd128);
            chk("d128_per",  32'(vq[vb].per),  32'd256);
            chk("d128_lat",  vq[vb].stamp,     rq[rb + 1] + 27);
            chk("d128_rep",  vq[vb + 1].stamp - vq[vb].stamp, 32'd256);
            chk("d128_duty2", 32'(vq[vb + 1].duty), 32'd128);
        end

        // D=255.
        gen_en = 1'b0;
        tick(1);
        do_reset(r);
        vb = vq.size();
        start_gen(256, 255);
        wait_valids(vb + 1, 900, "d255_wait", ok);
        if (ok) begin
            chk("d255_duty", 32'(vq[vb].duty), 32'd255);
            chk("d255_ht",   32'(vq[vb].ht),   32'd255);
            chk("d255_per",  32'(vq[vb].per),  32'd256);
        end

        // D=1.
        gen_en = 1'b0;
        tick(1);
        do_reset(r);
        vb = vq.size();
        start_gen(256, 1);
        wait_valids(vb + 1, 900, "d1_wait", ok);
        if (ok) begin
            chk("d1_duty", 32'(vq[vb].duty), 32'd1);
            chk("d1_ht",   32'(vq[vb].ht),   32'd1);
            chk("d1_per",  32'(vq[vb].per),  32'd256);
        end

        // Stuck high: input high from reset, rise seen at R+2, timeout at R+3+1024.
        gen_en  = 1'b0;
        pwm_man = 1'b1;
        tick(1);
        do_reset(r);
        vb = vq.size();
        wait_valids(vb + 1, 1100, "sthi_wait", ok);
        if (ok) begin
            chk("sthi_stamp", vq[vb].stamp,      r + 1027);
            chk("sthi_duty",  32'(vq[vb].duty),  32'd255);
            chk("sthi_stuck", 32'(vq[vb].stuck), 32'd1);
            chk("sthi_ht",    32'(vq[vb].ht),    32'd0);
            chk("sthi_per",   32'(vq[vb].per),   32'd0);
        end

        // Stuck low: no edges from reset, timeout at R+1024; a rise clears stuck.
        pwm_man = 1'b0;
        tick(1);
        do_reset(r);
        vb = vq.size();
        wait_valids(vb + 1, 1100, "stlo_wait", ok);
        if (ok) begin
            chk("stlo_stamp", vq[vb].stamp,      r + 1024);
            chk("stlo_duty",  32'(vq[vb].duty),  32'd0);
            chk("stlo_stuck", 32'(vq[vb].stuck), 32'd1);
            tick(1);
            chk("stlo_pulse", 32'(valid), 32'd0);
            chk("stlo_hold",  32'(stuck), 32'd1);
            pwm_man = 1'b1;
            tick(5);
            chk("stlo_clear",   32'(stuck),     32'd0);
            chk("stlo_noval",   vq.size(),      vb + 1);
        end

        // Period 10, high 3: duty floor(768/10)=76, latency check.
        pwm_man = 1'b0;
        tick(1);
        do_reset(r);
        rb = rq.size();
        vb = vq.size();
        start_gen(10, 3);
        wait_valids(vb + 1, 200, "p10_wait", ok);
        if (ok) begin
            chk("p10_duty", 32'(vq[vb].duty), 32'd76);
            chk("p10_ht",   32'(vq[vb].ht),   32'd3);
            chk("p10_per",  32'(vq[vb].per),  32'd10);
            chk("p10_lat",  vq[vb].stamp,     rq[rb + 1] + 27);
        end

        // Period 6, high 2: duty 85; four rises land while the divider is busy.
        gen_en = 1'b0;
        tick(1);
        do_reset(r);
        rb = rq.size();
        vb = vq.size();
        ob = oq.size();
        start_gen(6, 2);
        wait_valids(vb + 3, 300, "p6_wait", ok);
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("p6_duty%0d", i), 32'(vq[vb + i].duty), 32'd85);
                chk($sformatf("p6_ht%0d", i),   32'(vq[vb + i].ht),   32'd2);
                chk($sformatf("p6_per%0d", i),  32'(vq[vb + i].per),  32'd6);
            end
            n_ov = 0;
            for (int i = int'(ob); i < int'(oq.size()); i++)
                if (oq[i] < vq[vb].stamp) n_ov++;
            chk("p6_novr", n_ov, 32'd4);
            if (oq.size() > ob) chk("p6_ovr1", oq[ob], rq[rb + 2] + 2);
            else                chk("p6_ovr_seen", oq.size(), ob + 1);
        end

        // Reset mid-division aborts it; the next full period measures correctly.
        gen_en = 1'b0;
        tick(1);
        do_reset(r);
        rb = rq.size();
        start_gen(40, 5);
        k = 0;
        while (rq.size() < rb + 2 && k < 200) begin
            tick(1);
            k++;
        end
        chk("abort_rises", 32'(rq.size() >= rb + 2), 32'd1);
        if (rq.size() >= rb + 2) begin
            target = rq[rb + 1] + 12;
            while (cyc < target) tick(1);
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
            check_zero("abort");
            vb = vq.size();
            tick(20);
            chk("abort_noval", vq.size(), vb);
            wait_valids(vb + 1, 200, "abort_wait", ok);
            if (ok) begin
                chk("abort_duty", 32'(vq[vb].duty), 32'd32);
                chk("abort_ht",   32'(vq[vb].ht),   32'd5);
                chk("abort_per",  32'(vq[vb].per),  32'd40);
            end
        end

        gen_en = 1'b0;
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
